transfer_ctrl: RTL and testbench

Frame-level sequencer that drives the address calculator and the SDRAM/SRAM memory wrappers. For each image row it moves `image_width` pixels from SDRAM into the SRAM row cache, hands off to the compute engine, then copies `image_width-1` results from the SRAM output region back to SDRAM. It owns the `sram_mode`, `sdram_mode`, `update` and `start_flag` inputs of the address calculator, and provides a one-word buffer between the memory read and write ports.

---
 rtl/xfer_pkg.sv | 21 ++
 rtl/xfer_counter.sv | 27 ++
 rtl/transfer_ctrl.sv | 137 +++++++++++++
 tb/tb_transfer_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xfer_pkg.sv
// Shared definitions for the frame transfer sequencer: state encoding,
// counter width and default data width.
package xfer_pkg;

  localparam int DIM_W          = 13;
  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    INIT    = 4'd1,
    LD_RD   = 4'd2,
    LD_WR   = 4'd3,
    LD_NEXT = 4'd4,
    COMPUTE = 4'd5,
    ST_RD   = 4'd6,
    ST_WR   = 4'd7,
    ST_NEXT = 4'd8,
    FIN     = 4'd9
  } xfer_state_t;

endpackage

// File: rtl/xfer_counter.sv
// Unsigned element/row counter with synchronous clear, increment and a
// terminal-value compare against a caller-supplied limit.
module xfer_counter
  import xfer_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             inc,
  input  logic [DIM_W-1:0] term,
  output logic             at_term
);

  logic [DIM_W-1:0] count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc)
      count <= count + 1'b1;
  end

  assign at_term = (count == term);

endmodule

// File: rtl/transfer_ctrl.sv
// Row-by-row frame sequencer: loads a row from SDRAM into the SRAM cache,
// triggers compute, then stores width-1 results back, through a one-word buffer.
module transfer_ctrl
  import xfer_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start_flag,
  input  logic [DIM_W-1:0]  image_width,
  input  logic [DIM_W-1:0]  image_height,
  input  logic              sdram_done,
  input  logic              sram_done,
  input  logic [DATA_W-1:0] sdram_rdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              compute_done,
  output logic              sdram_read,
  output logic              sdram_write,
  output logic              sram_read,
  output logic              sram_write,
  output logic [DATA_W-1:0] wdata,
  output logic              addr_start,
  output logic              update,
  output logic              sram_mode,
  output logic              sdram_mode,
  output logic              compute_start,
  output logic              busy,
  output logic              done
);

  xfer_state_t       state, next_state;
  logic [DIM_W-1:0]  width_q, height_q;
  logic [DATA_W-1:0] word_q;
  logic              start_ok;
  logic              col_at_term, row_at_term;
  logic              col_clear, col_inc, row_clear, row_inc;
  logic [DIM_W-1:0]  col_term, row_term;

  assign start_ok = (state == IDLE) && start_flag;

  // Load rows copy width words, store rows copy width-1 results.
  assign col_term  = (state == ST_NEXT) ? (width_q - 13'd2) : (width_q - 13'd1);
  assign row_term  = height_q - 13'd1;
  assign col_clear = start_ok || (((state == LD_NEXT) || (state == ST_NEXT)) && col_at_term);
  assign col_inc   = ((state == LD_NEXT) || (state == ST_NEXT)) && !col_at_term;
  assign row_clear = start_ok;
  assign row_inc   = (state == ST_NEXT) && col_at_term && !row_at_term;

  xfer_counter u_col_cnt (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (col_clear),
    .inc     (col_inc),
    .term    (col_term),
    .at_term (col_at_term)
  );

  xfer_counter u_row_cnt (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (row_clear),
    .inc     (row_inc),
    .term    (row_term),
    .at_term (row_at_term)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_flag) begin
          if ((image_width < 13'd2) || (image_height == 13'd0))
            next_state = FIN;
          else
            next_state = INIT;
        end
      end
      INIT:    next_state = LD_RD;
      LD_RD:   if (sdram_done) next_state = LD_WR;
      LD_WR:   if (sram_done) next_state = LD_NEXT;
      LD_NEXT: next_state = col_at_term ? COMPUTE : LD_RD;
      COMPUTE: if (compute_done) next_state = ST_RD;
      ST_RD:   if (sram_done) next_state = ST_WR;
      ST_WR:   if (sdram_done) next_state = ST_NEXT;
      ST_NEXT: begin
        if (!col_at_term)
          next_state = ST_RD;
        else if (row_at_term)
          next_state = FIN;
        else
          next_state = LD_RD;
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      width_q       <= '0;
      height_q      <= '0;
      compute_start <= 1'b0;
    end else begin
      state         <= next_state;
      compute_start <= (next_state == COMPUTE) && (state != COMPUTE);
      if (start_ok) begin
        width_q  <= image_width;
        height_q <= image_height;
      end
    end
  end

  // The buffer only captures read data while the matching read is pending.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      word_q <= '0;
    else if ((state == LD_RD) && sdram_done)
      word_q <= sdram_rdata;
    else if ((state == ST_RD) && sram_done)
      word_q <= sram_rdata;
  end

  assign wdata       = word_q;
  assign sdram_read  = (state == LD_RD);
  assign sram_write  = (state == LD_WR);
  assign sram_read   = (state == ST_RD);
  assign sdram_write = (state == ST_WR);
  assign addr_start  = (state == INIT);
  assign update      = (state == LD_NEXT) || (state == ST_NEXT);
  assign busy        = (state != IDLE);
  assign done        = (state == FIN);
  assign sram_mode   = !((state == ST_RD) || (state == ST_WR) || (state == ST_NEXT));
  assign sdram_mode  = sram_mode;

endmodule

// File: tb/tb_transfer_ctrl.sv
// Directed bench for transfer_ctrl with behavioural memory/compute models and
// a scoreboard tracking words from each read grant to the following write.
module tb_transfer_ctrl;

  logic        clk;
  logic        n_rst;
  logic        start_flag;
  logic [12:0] image_width;
  logic [12:0] image_height;
  logic        sdram_done;
  logic        sram_done;
  logic [31:0] sdram_rdata;
  logic [31:0] sram_rdata;
  logic        compute_done;
  logic        sdram_read, sdram_write, sram_read, sram_write;
  logic [31:0] wdata;
  logic        addr_start, update, sram_mode, sdram_mode;
  logic        compute_start, busy, done;

  transfer_ctrl #(.DATA_W(32)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .start_flag    (start_flag),
    .image_width   (image_width),
    .image_height  (image_height),
    .sdram_done    (sdram_done),
    .sram_done     (sram_done),
    .sdram_rdata   (sdram_rdata),
    .sram_rdata    (sram_rdata),
    .compute_done  (compute_done),
    .sdram_read    (sdram_read),
    .sdram_write   (sdram_write),
    .sram_read     (sram_read),
    .sram_write    (sram_write),
    .wdata         (wdata),
    .addr_start    (addr_start),
    .update        (update),
    .sram_mode     (sram_mode),
    .sdram_mode    (sdram_mode),
    .compute_start (compute_start),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks, errors;
  int cyc;
  int sd_lat, sr_lat, cd_delay;
  int sd_wait, sr_wait, cd_cnt;
  int rd_sd, wr_sd, rd_sr, wr_sr;
  int upd_cnt, cs_cnt, as_cnt, dn_cnt, dn_cyc;
  int ld_seq, st_seq;
  int wr_run, max_wr_run;
  logic        seen_ld_w, seen_st_w;
  logic [31:0] first_ld_w, first_st_w;
  logic [31:0] ld_q[$];
  logic [31:0] st_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    rd_sd = 0; wr_sd = 0; rd_sr = 0; wr_sr = 0;
    upd_cnt = 0; cs_cnt = 0; as_cnt = 0; dn_cnt = 0; dn_cyc = 0;
    ld_seq = 0; st_seq = 0; wr_run = 0; max_wr_run = 0;
    seen_ld_w = 1'b0; seen_st_w = 1'b0;
    first_ld_w = '0; first_st_w = '0;
  endtask

  // One clock of the environment: observe DUT outputs at the falling edge,
  // then drive memory/compute responses for the next rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (!n_rst) begin
      ld_q.delete(); st_q.delete();
      sdram_done = 1'b0; sram_done = 1'b0; compute_done = 1'b0;
      sd_wait = 0; sr_wait = 0; cd_cnt = 0; wr_run = 0;
      return;
    end
    if (sdram_read || sram_write) begin
      check("mode_ld_sram", sram_mode, 1);
      check("mode_ld_sdram", sdram_mode, 1);
    end
    if (sram_read || sdram_write) begin
      check("mode_st_sram", sram_mode, 0);
      check("mode_st_sdram", sdram_mode, 0);
    end
    if (sram_write) begin
      check("ld_depth", ld_q.size(), 1);
      if (ld_q.size() > 0) check("ld_pass", wdata, ld_q[0]);
      if (!seen_ld_w) begin first_ld_w = wdata; seen_ld_w = 1'b1; end
      wr_run++;
      if (wr_run > max_wr_run) max_wr_run = wr_run;
    end else begin
      wr_run = 0;
    end
    if (sdram_write) begin
      check("st_depth", st_q.size(), 1);
      if (st_q.size() > 0) check("st_pass", wdata, st_q[0]);
      if (!seen_st_w) begin first_st_w = wdata; seen_st_w = 1'b1; end
    end
    if (update) upd_cnt++;
    if (addr_start) as_cnt++;
    if (done) begin
      dn_cnt++;
      if (dn_cyc == 0) dn_cyc = cyc;
    end
    compute_done = 1'b0;
    if (cd_cnt > 0) begin
      cd_cnt--;
      if (cd_cnt == 0) compute_done = 1'b1;
    end
    if (compute_start) begin
      cs_cnt++;
      if (cd_delay == 0) compute_done = 1'b1;
      else cd_cnt = cd_delay;
    end
    if (sdram_read || sdram_write) begin
      sdram_done = (sd_wait == sd_lat);
      sd_wait++;
      if (sdram_done && sdram_read) begin
        rd_sd++;
        sdram_rdata = (ld_seq == 0) ? 32'hDEADBEEF : $urandom;
        ld_seq++;
        ld_q.push_back(sdram_rdata);
      end
      if (sdram_done && sdram_write) begin
        wr_sd++;
        if (st_q.size() > 0) void'(st_q.pop_front());
      end
    end else begin
      sdram_done = 1'b0;
      sd_wait = 0;
    end
    if (sram_read || sram_write) begin
      sram_done = (sr_wait == sr_lat);
      sr_wait++;
      if (sram_done && sram_read) begin
        rd_sr++;
        sram_rdata = (st_seq == 0) ? 32'h12345678 : $urandom;
        st_seq++;
        st_q.push_back(sram_rdata);
      end
      if (sram_done && sram_write) begin
        wr_sr++;
        if (ld_q.size() > 0) void'(ld_q.pop_front());
      end
    end else begin
      sram_done = 1'b0;
      sr_wait = 0;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sdram_read"}, sdram_read, 0);
    check({tag, "_sdram_write"}, sdram_write, 0);
    check({tag, "_sram_read"}, sram_read, 0);
    check({tag, "_sram_write"}, sram_write, 0);
    check({tag, "_wdata"}, wdata, 0);
    check({tag, "_addr_start"}, addr_start, 0);
    check({tag, "_update"}, update, 0);
    check({tag, "_compute_start"}, compute_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sram_mode"}, sram_mode, 1);
    check({tag, "_sdram_mode"}, sdram_mode, 1);
  endtask

  task automatic apply_stimulus(input int w, input int h, input int budget);
    int n;
    int start_cyc;
    clear_counts();
    image_width  = 13'(w);
    image_height = 13'(h);
    start_flag   = 1'b1;
    start_cyc    = cyc;
    step();
    start_flag   = 1'b0;
    check("addr_start_latency", addr_start, (w >= 2 && h != 0) ? 1 : 0);
    check("busy_after_start", busy, 1);
    n = 0;
    while (dn_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    check("frame_done_count", dn_cnt, 1);
    check("done_latency_ok", (dn_cyc - start_cyc >= 1) && (dn_cyc - start_cyc <= 2) ? 1 : 0,
          (w < 2 || h == 0) ? 1 : 0);
    step();
    check("busy_after_frame", busy, 0);
    check("single_done", dn_cnt, 1);
  endtask

  task automatic check_output(input string tag, input int loads, input int stores,
                              input int rows_computed, input int addr_pulses);
    check({tag, "_sdram_read_grants"}, rd_sd, loads);
    check({tag, "_sram_write_grants"}, wr_sr, loads);
    check({tag, "_sram_read_grants"}, rd_sr, stores);
    check({tag, "_sdram_write_grants"}, wr_sd, stores);
    check({tag, "_update_pulses"}, upd_cnt, loads + stores);
    check({tag, "_compute_starts"}, cs_cnt, rows_computed);
    check({tag, "_addr_starts"}, as_cnt, addr_pulses);
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; cyc = 0;
    sd_lat = 0; sr_lat = 0; cd_delay = 2;
    sd_wait = 0; sr_wait = 0; cd_cnt = 0;
    clear_counts();
    n_rst = 1'b0;
    start_flag = 1'b0;
    image_width = '0;
    image_height = '0;
    sdram_done = 1'b0; sram_done = 1'b0; compute_done = 1'b0;
    sdram_rdata = '0; sram_rdata = '0;

    step(); step();
    check_reset_values("reset");
    n_rst = 1'b1;
    step();

    // Nominal frame with zero-wait memories.
    apply_stimulus(4, 2, 500);
    check_output("w4h2", 8, 6, 2, 1);
    check("first_load_word", first_ld_w, 32'hDEADBEEF);
    check("first_store_word", first_st_w, 32'h12345678);

    // Degenerate frames finish without touching memory.
    apply_stimulus(1, 5, 10);
    check_output("w1h5", 0, 0, 0, 0);
    apply_stimulus(4, 0, 10);
    check_output("w4h0", 0, 0, 0, 0);

    // Slow SRAM and compute_done on the compute entry cycle.
    sr_lat = 3; cd_delay = 0;
    apply_stimulus(2, 1, 200);
    check_output("w2h1_slow", 2, 1, 1, 1);
    check("sram_write_hold", max_wr_run, 4);
    sr_lat = 0; cd_delay = 2;

    // Mid-frame start is ignored; reset during a store write aborts the frame.
    clear_counts();
    sd_lat = 2;
    image_width = 13'd3; image_height = 13'd2;
    start_flag = 1'b1;
    step();
    start_flag = 1'b0;
    repeat (3) step();
    image_width = 13'd1;
    start_flag = 1'b1;
    step();
    start_flag = 1'b0;
    check("ignored_start_busy", busy, 1);
    check("ignored_start_addr", as_cnt, 1);
    n = 0;
    while (sdram_write !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("reach_st_wr", sdram_write, 1);
    #2 n_rst = 1'b0;
    #1 check_reset_values("midreset");
    step();
    n_rst = 1'b1;
    repeat (3) step();
    check("no_done_after_reset", dn_cnt, 0);
    check("idle_after_reset", busy, 0);
    sd_lat = 0;

    apply_stimulus(3, 2, 500);
    check_output("w3h2_rerun", 6, 4, 2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
